f_ifetch: RTL and testbench
===========================

# f_ifetch

Instruction-fetch responder for the F stage of the pipelined MIPS core. It takes the current fetch address from the PC register and checks it for alignment and range. For a legal address it runs a request/acknowledge read on the instruction-memory port; for an illegal one it raises AdEL. It then presents the instruction, its PC and an exception code to the F/D boundary, and drives the PC register's write-enable so the PC advances only when D accepts the fetched instruction.

## Interface
Parameters:
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_TOP, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- PC  in  32  current fetch address from the PC register
- Req  in  1  exception/interrupt flush; the PC register loads the handler address on the same edge
- D_Stall  in  1  D stage cannot accept an instruction this cycle
- PC_WE  out  1  write-enable to the PC register (combinational)
- IM_Req  out  1  instruction-memory read request (registered)
- IM_Addr  out  32  instruction-memory read address (registered)
- IM_Ack  in  1  memory response valid
- IM_RData  in  32  instruction word, sampled when IM_Ack=1
- F_Valid  out  1  F_Instr/F_PC/F_ExcCode hold a fetched instruction
- F_Instr  out  32  fetched instruction; 0 (nop) when an exception is flagged
- F_PC  out  32  address the instruction was fetched from
- F_ExcCode  out  5  0 = none, 4 = AdEL on fetch

## Operation
- Four states:
  - IDLE: evaluate PC.
  - WAIT: request outstanding.
  - DONE: instruction held for D.
  - DRAIN: flushed request awaiting its ack.
- Legal address: PC[1:0]==0 and IM_BASE <= PC <= IM_TOP, compared unsigned.
- IDLE, Req=0:
  - Legal PC: on the edge set IM_Addr<=PC, IM_Req<=1, F_PC<=PC; go to WAIT.
  - Illegal PC: set F_Instr<=0, F_ExcCode<=4, F_PC<=PC, F_Valid<=1; go to DONE. No memory request is issued.
- WAIT:
  - IM_Req and IM_Addr stay stable until IM_Ack.
  - On IM_Ack: F_Instr<=IM_RData, F_ExcCode<=0, F_Valid<=1, IM_Req<=0; go to DONE.
- DONE:
  - PC_WE = !D_Stall && !Req.
  - When D_Stall=0 (handoff): F_Valid<=0; go to IDLE. The PC register advances on that same edge.
  - When D_Stall=1: all F_* outputs hold.
- PC_WE is 0 in every state other than DONE.
- Req has the highest priority and is evaluated in every state:
  - IDLE or DONE: F_Valid<=0; go to IDLE.
  - WAIT with IM_Ack=1: discard the data, IM_Req<=0, F_Valid stays 0; go to IDLE.
  - WAIT with IM_Ack=0: go to DRAIN. IM_Req and IM_Addr stay unchanged, because a request is never withdrawn before its ack.
  - DRAIN: on IM_Ack, IM_Req<=0 and the data is discarded; go to IDLE. A Req in DRAIN keeps the state in DRAIN.
- The instruction bus reaches D only through the F_* registers. PC is never forwarded combinationally.

## Timing
- Reset values: state=IDLE, IM_Req=0, IM_Addr=0, F_Valid=0, F_Instr=0, F_PC=0, F_ExcCode=0.
- PC_WE=0 while reset is asserted.
- Reset asserted mid-WAIT drops IM_Req asynchronously. Memory must tolerate an abandoned request on reset.
- Legal fetch with IM_Ack on the first WAIT cycle:
  - Edge 1: IDLE to WAIT.
  - Edge 2: WAIT to DONE; F_Valid=1 after edge 2.
  - Edge 3: handoff if D_Stall=0.
  - Throughput is one instruction per 3 cycles at zero memory wait states. Each extra wait cycle adds 1.
- Exception fetch: F_Valid=1 one edge after IDLE; handoff on the next edge with D_Stall=0.
- IM_Ack is ignored in IDLE and DONE.
- Req and handoff in the same cycle: Req wins; PC_WE=0 and F_Valid clears.
- After any Req, the first fetch of the handler address starts in IDLE on the following cycle. If draining, it starts on the cycle after the drain ack.

## Test plan
- Reset, PC=0x3000, memory returns 0x2408_0001 with IM_Ack one cycle after IM_Req -> IM_Addr=0x3000, F_Valid=1, F_Instr=0x24080001, F_ExcCode=0. PC_WE pulses for exactly one cycle, on the handoff edge.
- PC=0x3002, then PC=0x2FFC, then PC=0x7000 -> no IM_Req for any of them. Each gives F_Valid=1, F_Instr=0, F_ExcCode=4, with F_PC equal to the offending address.
- Fetch completes with D_Stall held for 4 cycles -> F_* stable and PC_WE=0 for those 4 cycles. Handoff on the first cycle with D_Stall=0.
- Req asserted in WAIT with memory ack delayed 3 cycles -> enters DRAIN, IM_Req held at the old address until the ack, data discarded, F_Valid stays 0. The next fetch uses the handler PC 0x4180.
- Req in the same cycle as IM_Ack, and separately in the same cycle as a DONE handoff -> F_Valid=0 and PC_WE=0; next state IDLE.
- Asynchronous reset pulse mid-WAIT, between clock edges -> IM_Req, F_Valid and state clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/f_ifetch.sv
// F-stage instruction fetch: alignment/range check, req/ack IM read, F/D output registers, PC write-enable.
// Latency 2 edges to F_Valid for a zero-wait fetch; holds while D_Stall; a request is never withdrawn before its ack.
module f_ifetch #(
  parameter logic [31:0] IM_BASE = 32'h0000_3000,
  parameter logic [31:0] IM_TOP  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        Req,
  input  logic        D_Stall,
  output logic        PC_WE,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_RData,
  output logic        F_Valid,
  output logic [31:0] F_Instr,
  output logic [31:0] F_PC,
  output logic [4:0]  F_ExcCode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  state_t      state_q, state_d;
  logic        im_req_q, im_req_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_instr_q, f_instr_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [4:0]  f_exc_q, f_exc_d;
  logic        pc_legal;

  assign pc_legal = (PC[1:0] == 2'b00) && (PC >= IM_BASE) && (PC <= IM_TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      im_req_q  <= 1'b0;
      im_addr_q <= 32'd0;
      f_valid_q <= 1'b0;
      f_instr_q <= 32'd0;
      f_pc_q    <= 32'd0;
      f_exc_q   <= EXC_NONE;
    end else begin
      state_q   <= state_d;
      im_req_q  <= im_req_d;
      im_addr_q <= im_addr_d;
      f_valid_q <= f_valid_d;
      f_instr_q <= f_instr_d;
      f_pc_q    <= f_pc_d;
      f_exc_q   <= f_exc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    im_req_d  = im_req_q;
    im_addr_d = im_addr_q;
    f_valid_d = f_valid_q;
    f_instr_d = f_instr_q;
    f_pc_d    = f_pc_q;
    f_exc_d   = f_exc_q;
    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          f_valid_d = 1'b0;
        end else if (pc_legal) begin
          im_addr_d = PC;
          im_req_d  = 1'b1;
          f_pc_d    = PC;
          state_d   = S_WAIT;
        end else begin
          f_instr_d = 32'd0;
          f_exc_d   = EXC_ADEL;
          f_pc_d    = PC;
          f_valid_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_WAIT: begin
        // A flush without ack must still wait out the outstanding read.
        if (Req) begin
          if (IM_Ack) begin
            im_req_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_DRAIN;
          end
        end else if (IM_Ack) begin
          f_instr_d = IM_RData;
          f_exc_d   = EXC_NONE;
          f_valid_d = 1'b1;
          im_req_d  = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (Req || !D_Stall) begin
          f_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (IM_Ack) begin
          im_req_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign PC_WE     = !reset && (state_q == S_DONE) && !D_Stall && !Req;
  assign IM_Req    = im_req_q;
  assign IM_Addr   = im_addr_q;
  assign F_Valid   = f_valid_q;
  assign F_Instr   = f_instr_q;
  assign F_PC      = f_pc_q;
  assign F_ExcCode = f_exc_q;

endmodule

// File: tb/tb_f_ifetch.sv
// Directed bench for f_ifetch: hand-computed expectations per step, checked 1 time unit after each rising edge.
module tb_f_ifetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        Req, D_Stall, IM_Ack;
  logic [31:0] IM_RData;
  logic        PC_WE, IM_Req, F_Valid;
  logic [31:0] IM_Addr, F_Instr, F_PC;
  logic [4:0]  F_ExcCode;

  int n_chk  = 0;
  int n_pass = 0;

  f_ifetch dut (
    .clk(clk), .reset(reset), .PC(PC), .Req(Req), .D_Stall(D_Stall),
    .PC_WE(PC_WE), .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Ack(IM_Ack),
    .IM_RData(IM_RData), .F_Valid(F_Valid), .F_Instr(F_Instr), .F_PC(F_PC),
    .F_ExcCode(F_ExcCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bad_pc [3];

  initial begin
    bad_pc[0] = 32'h0000_3002;
    bad_pc[1] = 32'h0000_2FFC;
    bad_pc[2] = 32'h0000_7000;
    reset = 1'b1; PC = 32'h0000_3000; Req = 1'b0; D_Stall = 1'b0;
    IM_Ack = 1'b0; IM_RData = 32'd0;
    tick();
    chk("rst_imreq", {31'd0, IM_Req}, 32'd0);
    chk("rst_imaddr", IM_Addr, 32'd0);
    chk("rst_fvalid", {31'd0, F_Valid}, 32'd0);
    chk("rst_finstr", F_Instr, 32'd0);
    chk("rst_fpc", F_PC, 32'd0);
    chk("rst_exc", {27'd0, F_ExcCode}, 32'd0);
    chk("rst_pcwe", {31'd0, PC_WE}, 32'd0);
    reset = 1'b0;

    // Basic zero-wait fetch
    tick();
    chk("f1_imreq", {31'd0, IM_Req}, 32'd1);
    chk("f1_imaddr", IM_Addr, 32'h0000_3000);
    chk("f1_pcwe_wait", {31'd0, PC_WE}, 32'd0);
    IM_Ack = 1'b1; IM_RData = 32'h2408_0001;
    tick();
    IM_Ack = 1'b0;
    chk("f1_fvalid", {31'd0, F_Valid}, 32'd1);
    chk("f1_finstr", F_Instr, 32'h2408_0001);
    chk("f1_exc", {27'd0, F_ExcCode}, 32'd0);
    chk("f1_fpc", F_PC, 32'h0000_3000);
    chk("f1_imreq_off", {31'd0, IM_Req}, 32'd0);
    chk("f1_pcwe_done", {31'd0, PC_WE}, 32'd1);
    PC = bad_pc[0];
    tick();
    chk("f1_fvalid_hand", {31'd0, F_Valid}, 32'd0);
    chk("f1_pcwe_idle", {31'd0, PC_WE}, 32'd0);

    // Illegal addresses raise AdEL without touching memory
    for (int i = 0; i < 3; i++) begin
      PC = bad_pc[i];
      tick();
      chk("adel_imreq", {31'd0, IM_Req}, 32'd0);
      chk("adel_fvalid", {31'd0, F_Valid}, 32'd1);
      chk("adel_finstr", F_Instr, 32'd0);
      chk("adel_exc", {27'd0, F_ExcCode}, 32'd4);
      chk("adel_fpc", F_PC, bad_pc[i]);
      chk("adel_pcwe", {31'd0, PC_WE}, 32'd1);
      tick();
      chk("adel_hand", {31'd0, F_Valid}, 32'd0);
    end

    // Top-of-range fetch, one wait state, D stalled for 4 cycles
    PC = 32'h0000_6FFC;
    tick();
    chk("st_imaddr", IM_Addr, 32'h0000_6FFC);
    tick();
    chk("st_wait_imreq", {31'd0, IM_Req}, 32'd1);
    chk("st_wait_fvalid", {31'd0, F_Valid}, 32'd0);
    IM_Ack = 1'b1; IM_RData = 32'hDEAD_BEEF; D_Stall = 1'b1;
    tick();
    IM_Ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_pcwe", {31'd0, PC_WE}, 32'd0);
      chk("st_fvalid", {31'd0, F_Valid}, 32'd1);
      chk("st_finstr", F_Instr, 32'hDEAD_BEEF);
      chk("st_fpc", F_PC, 32'h0000_6FFC);
      tick();
    end
    D_Stall = 1'b0; PC = 32'h0000_3004;
    #1 chk("st_pcwe_hand", {31'd0, PC_WE}, 32'd1);
    tick();
    chk("st_fvalid_hand", {31'd0, F_Valid}, 32'd0);

    // Flush in WAIT: drain a delayed ack, then fetch the handler
    tick();
    chk("dr_imaddr", IM_Addr, 32'h0000_3004);
    Req = 1'b1;
    #1 chk("dr_pcwe", {31'd0, PC_WE}, 32'd0);
    tick();
    PC = 32'h0000_4180;
    tick();
    Req = 1'b0;
    chk("dr_hold_imreq", {31'd0, IM_Req}, 32'd1);
    tick();
    chk("dr_hold_imaddr", IM_Addr, 32'h0000_3004);
    chk("dr_fvalid", {31'd0, F_Valid}, 32'd0);
    IM_Ack = 1'b1; IM_RData = 32'h1111_1111;
    tick();
    IM_Ack = 1'b0;
    chk("dr_ack_imreq", {31'd0, IM_Req}, 32'd0);
    chk("dr_ack_fvalid", {31'd0, F_Valid}, 32'd0);
    tick();
    chk("hnd_imreq", {31'd0, IM_Req}, 32'd1);
    chk("hnd_imaddr", IM_Addr, 32'h0000_4180);
    IM_Ack = 1'b1; IM_RData = 32'h0000_000C;
    tick();
    IM_Ack = 1'b0;
    chk("hnd_finstr", F_Instr, 32'h0000_000C);

    // Flush coinciding with DONE handoff
    Req = 1'b1;
    #1 chk("rqh_pcwe", {31'd0, PC_WE}, 32'd0);
    tick();
    Req = 1'b0;
    chk("rqh_fvalid", {31'd0, F_Valid}, 32'd0);
    tick();
    chk("rqh_idle_fetch", {31'd0, IM_Req}, 32'd1);

    // Flush coinciding with IM_Ack
    Req = 1'b1; IM_Ack = 1'b1; IM_RData = 32'h2222_2222;
    tick();
    Req = 1'b0; IM_Ack = 1'b0;
    chk("rqa_imreq", {31'd0, IM_Req}, 32'd0);
    chk("rqa_fvalid", {31'd0, F_Valid}, 32'd0);
    tick();
    chk("rqa_idle_fetch", {31'd0, IM_Req}, 32'd1);

    // Asynchronous reset pulse between edges while in WAIT
    #3 reset = 1'b1;
    #1;
    chk("ar_imreq", {31'd0, IM_Req}, 32'd0);
    chk("ar_imaddr", IM_Addr, 32'd0);
    chk("ar_fvalid", {31'd0, F_Valid}, 32'd0);
    chk("ar_pcwe", {31'd0, PC_WE}, 32'd0);
    #1 reset = 1'b0;
    PC = 32'h0000_0001;
    tick();
    chk("ar_idle_exc", {27'd0, F_ExcCode}, 32'd4);
    chk("ar_idle_fpc", F_PC, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
